// File: rtl/pe_share_arbiter.sv
// Shares one fixed-latency, tagless processing element among NUM_REQ requesters.
// Round-robin issue, shadow tag pipeline, and credit-protected per-requester response FIFOs.
module pe_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LATENCY = 15,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           pe_data_in,
    input  logic [WIDTH-1:0]           pe_data_out,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [NUM_REQ*WIDTH-1:0]   rsp_data,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic                       busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned INF_W = $clog2(LATENCY + 1);

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [IDX_W-1:0]   tag_own_q [LATENCY];
    logic [IDX_W-1:0]   tag_own_d [LATENCY];
    logic [CNT_W-1:0]   count_q [NUM_REQ];
    logic [CNT_W-1:0]   count_d [NUM_REQ];
    logic [PTR_W-1:0]   rd_q [NUM_REQ];
    logic [PTR_W-1:0]   rd_d [NUM_REQ];
    logic [PTR_W-1:0]   wr_q [NUM_REQ];
    logic [PTR_W-1:0]   wr_d [NUM_REQ];
    logic [WIDTH-1:0]   mem_q [NUM_REQ][DEPTH];

    logic [INF_W-1:0]   inflight [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic               issue;
    logic [IDX_W-1:0]   grant_idx;
    logic [31:0]        cand;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit from registered state only: free = DEPTH - (queued + in flight)
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            inflight[i] = '0;
            for (int s = 0; s < LATENCY; s++) begin
                if (tag_vld_q[s] && (tag_own_q[s] == IDX_W'(i))) begin
                    inflight[i] = inflight[i] + INF_W'(1);
                end
            end
            eligible[i] = req_valid[i] &&
                          ((32'(count_q[i]) + 32'(inflight[i])) < 32'(DEPTH));
        end
    end

    // Round-robin grant starting at the pointer; gated off while in reset
    always_comb begin
        issue     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr_q) + 32'(k)) % 32'(NUM_REQ);
            if (!issue && eligible[IDX_W'(cand)]) begin
                issue     = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        issue     = issue && rst;
        req_ready = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
        end
        pe_data_in = issue ? req_data[32'(grant_idx)*WIDTH +: WIDTH] : '0;
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Tag pipeline shift and FIFO pointer/count updates
    always_comb begin
        tag_vld_d[0] = issue;
        tag_own_d[0] = grant_idx;
        for (int s = 1; s < LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_own_d[s] = tag_own_q[s-1];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            push[i]    = tag_vld_q[LATENCY-1] && (tag_own_q[LATENCY-1] == IDX_W'(i));
            pop[i]     = rsp_valid[i] && rsp_ready[i];
            count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            wr_d[i]    = push[i] ? ptr_inc(wr_q[i]) : wr_q[i];
            rd_d[i]    = pop[i]  ? ptr_inc(rd_q[i]) : rd_q[i];
        end
    end

    // FIFO heads are presented as zero when empty so reset leaves rsp_data at 0
    always_comb begin
        busy     = |tag_vld_q;
        rsp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (count_q[i] != '0);
            if (rsp_valid[i]) begin
                rsp_data[i*WIDTH +: WIDTH] = mem_q[i][rd_q[i]];
            end
            busy = busy | rsp_valid[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            tag_vld_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_own_q[s] <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                count_q[i] <= '0;
                rd_q[i]    <= '0;
                wr_q[i]    <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            tag_vld_q <= tag_vld_d;
            for (int s = 0; s < LATENCY; s++) begin
                tag_own_q[s] <= tag_own_d[s];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                count_q[i] <= count_d[i];
                rd_q[i]    <= rd_d[i];
                wr_q[i]    <= wr_d[i];
            end
        end
    end

    // Storage needs no reset: validity lives entirely in the counts
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem_q[i][wr_q[i]] <= pe_data_out;
            end
        end
    end

endmodule

// File: tb/tb_pe_share_arbiter.sv
// Scoreboard bench for pe_share_arbiter with a tagless identity PE model of the same latency.
module tb_pe_share_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned L  = 15;
    localparam int unsigned D  = 4;

    typedef struct {
        logic [W-1:0] data;
        int           acc;
        bit           lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic [W-1:0]      pe_data_in;
    logic [W-1:0]      pe_data_out;
    logic [NR-1:0]     rsp_valid;
    logic [NR*W-1:0]   rsp_data;
    logic [NR-1:0]     rsp_ready;
    logic              busy;

    logic [W-1:0]      pe_pipe [L];
    exp_t              sb    [NR][$];
    logic [W-1:0]      sendq [NR][$];
    int                glog [$];
    int                acc_cnt  [NR] = '{default: 0};
    int                last_acc [NR] = '{default: 0};
    int                cyc    = 0;
    int                errors = 0;
    int                checks = 0;
    bit                lat_mode = 1'b0;
    bit                log_en   = 1'b0;
    logic [NR-1:0]     force_v  = '0;

    pe_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .pe_data_in (pe_data_in),
        .pe_data_out(pe_data_out),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Identity PE with no reset, no valid and no tag
    always @(posedge clk) begin
        pe_pipe[0] <= pe_data_in;
        for (int s = 1; s < L; s++) pe_pipe[s] <= pe_pipe[s-1];
    end
    assign pe_data_out = pe_pipe[L-1];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NR; i++)
            if (sb[i].size() != 0 || sendq[i].size() != 0) return 1'b0;
        return !busy;
    endfunction

    task automatic drain(input string tag, input int max);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < max) begin
            @(negedge clk);
            done = all_idle();
            n++;
        end
        check_eq(tag, done, 1);
    endtask

    task automatic step_drive();
        @(posedge clk);
        #1;
    endtask

    // Driver: present the head of each send queue
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = force_v[i] | (sendq[i].size() > 0);
            req_data[i*W +: W] = (sendq[i].size() > 0) ? sendq[i][0] : '0;
        end
    end

    // Monitor: handshakes are decided by the settled values at the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check_eq("grant_onehot", ($countones(req_ready) <= 1), 1);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i] && sendq[i].size() > 0) begin
                    e.data = sendq[i].pop_front();
                    e.acc  = cyc + 1;
                    e.lat  = lat_mode;
                    check_eq("pe_data_in", pe_data_in, e.data);
                    sb[i].push_back(e);
                    check_eq("credit_bound", (sb[i].size() <= D), 1);
                    acc_cnt[i]++;
                    last_acc[i] = cyc + 1;
                    if (log_en) glog.push_back(i);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (sb[i].size() == 0) begin
                        check_eq("spurious_rsp", rsp_valid[i], 0);
                    end else begin
                        e = sb[i].pop_front();
                        check_eq("rsp_data", rsp_data[i*W +: W], e.data);
                        if (e.lat) check_eq("rsp_latency", cyc - e.acc, L);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time budget at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, a1, a3, base, n;

        // Reset with all requesters asserting valid
        rst       = 1'b0;
        rsp_ready = '0;
        force_v   = '1;
        @(posedge clk);
        #2;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_pe_data_in", pe_data_in, 0);
        check_eq("rst_busy", busy, 0);
        force_v = '0;
        @(posedge clk);
        #3;
        rst = 1'b1;

        // Idle
        rsp_ready = '1;
        repeat (30) begin
            @(negedge clk);
            check_eq("idle_pe_in", pe_data_in, 0);
            check_eq("idle_rsp_valid", rsp_valid, 0);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_req_ready", req_ready, 0);
        end

        // All requesters streaming: strict round-robin order
        lat_mode = 1'b1;
        log_en   = 1'b1;
        glog.delete();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 6; k++) sendq[i].push_back(16'(i*256 + k + 1));
        drain("rr_drain", 400);
        log_en = 1'b0;
        check_eq("rr_count", glog.size(), 24);
        for (int k = 0; k < glog.size(); k++) check_eq("rr_order", glog[k], k % NR);

        // Single token from requester 2
        base = acc_cnt[2];
        sendq[2].push_back(16'h00A5);
        repeat (3) @(negedge clk);
        check_eq("single_accept", acc_cnt[2], base + 1);
        repeat (10) begin
            @(negedge clk);
            check_eq("single_busy", busy, 1);
        end
        drain("single_drain", 40);
        @(negedge clk);
        check_eq("single_busy_end", busy, 0);

        // Requester 1 stalled: credit exhausts, requester 0 keeps being served
        lat_mode = 1'b0;
        step_drive();
        rsp_ready = 4'b1101;
        a1 = acc_cnt[1];
        for (int k = 0; k < 10; k++) sendq[1].push_back(16'(k + 1));
        for (int k = 0; k < 30; k++) sendq[0].push_back(16'(16'h0100 + k));
        repeat (40) @(negedge clk);
        check_eq("stall_accepts", acc_cnt[1] - a1, 4);
        a0 = acc_cnt[0];
        repeat (20) begin
            @(negedge clk);
            check_eq("stall_blocked", req_ready[1], 0);
        end
        check_eq("stall_other_served", (acc_cnt[0] > a0), 1);
        step_drive();
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check_eq("pop_no_comb_credit", req_ready[1], 0);
        @(negedge clk);
        check_eq("pop_regrant", req_ready[1], 1);
        drain("stall_drain", 800);

        // Credit boundary: 3 queued + 1 in flight, pop coincides with writeback
        step_drive();
        rsp_ready = 4'b1110;
        base = acc_cnt[0];
        for (int k = 0; k < 5; k++) sendq[0].push_back(16'(16'h0C00 + k));
        n = 0;
        while (acc_cnt[0] < base + 4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("cb_four_accepts", acc_cnt[0], base + 4);
        a3 = last_acc[0];
        do step_drive(); while (cyc < a3 + L - 1);
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check_eq("cb_full_block", req_ready[0], 0);
        check_eq("cb_rsp_valid", rsp_valid[0], 1);
        step_drive();
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        check_eq("cb_regrant", req_ready[0], 1);
        step_drive();
        rsp_ready = '1;
        drain("cb_drain", 100);

        // Reset while six tokens are in flight
        lat_mode = 1'b1;
        sendq[0].push_back(16'h0E00);
        sendq[0].push_back(16'h0E01);
        sendq[1].push_back(16'h0E10);
        sendq[1].push_back(16'h0E11);
        sendq[2].push_back(16'h0E20);
        sendq[3].push_back(16'h0E30);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #3;
        rst     = 1'b0;
        force_v = '1;
        for (int i = 0; i < NR; i++) begin
            sb[i].delete();
            sendq[i].delete();
        end
        #1;
        check_eq("mid_rst_req_ready", req_ready, 0);
        check_eq("mid_rst_rsp_valid", rsp_valid, 0);
        check_eq("mid_rst_rsp_data", rsp_data, 0);
        check_eq("mid_rst_pe_in", pe_data_in, 0);
        check_eq("mid_rst_busy", busy, 0);
        @(posedge clk);
        force_v = '0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_eq("post_rst_no_rsp", rsp_valid, 0);
            check_eq("post_rst_busy", busy, 0);
        end
        glog.delete();
        log_en = 1'b1;
        for (int i = 0; i < NR; i++) sendq[i].push_back(16'(16'h0F00 + i));
        drain("post_rst_drain", 100);
        log_en = 1'b0;
        check_eq("post_rst_count", glog.size(), NR);
        for (int k = 0; k < glog.size(); k++) check_eq("post_rst_ptr", glog[k], k);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
